// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle RV32I sequencing controller.
// The TRAP state exists only when MC_TRAP_EN is defined.
package mc_pkg;

    localparam int ALU_CTRL_W_DEF = 5;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
`ifdef MC_TRAP_EN
        , S_TRAP
`endif
    } state_e;

    // Which ALU operation a state asks the decoder for
    typedef enum logic [1:0] {
        ACLS_ADD,
        ACLS_SUB,
        ACLS_SLT,
        ACLS_FUNCT
    } alu_class_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

    localparam logic [ALU_CTRL_W_DEF-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALU_CTRL_W_DEF-1:0] ALU_SUB  = 5'd1;
    localparam logic [ALU_CTRL_W_DEF-1:0] ALU_SLL  = 5'd2;
    localparam logic [ALU_CTRL_W_DEF-1:0] ALU_SLT  = 5'd3;
    localparam logic [ALU_CTRL_W_DEF-1:0] ALU_SLTU = 5'd4;
    localparam logic [ALU_CTRL_W_DEF-1:0] ALU_XOR  = 5'd5;
    localparam logic [ALU_CTRL_W_DEF-1:0] ALU_SRL  = 5'd6;
    localparam logic [ALU_CTRL_W_DEF-1:0] ALU_SRA  = 5'd7;
    localparam logic [ALU_CTRL_W_DEF-1:0] ALU_OR   = 5'd8;
    localparam logic [ALU_CTRL_W_DEF-1:0] ALU_AND  = 5'd9;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // Unsupported sizes fall back to a word access
    function automatic logic [1:0] mode_of(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return MODE_BYTE;
            3'b001:  return MODE_HALF;
            default: return MODE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation decoder: fixed operations for address/branch states, funct
// decoding for R-type and I-type execute states.
module mc_alu_decoder
    import mc_pkg::*;
#(
    parameter int ALU_CTRL_W = ALU_CTRL_W_DEF
) (
    input  alu_class_e            alu_class_i,
    input  logic [6:0]            opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    output logic [ALU_CTRL_W-1:0] alu_control_o
);

    logic [ALU_CTRL_W_DEF-1:0] code;

    always_comb begin
        code = ALU_ADD;
        case (alu_class_i)
            ACLS_SUB: code = ALU_SUB;
            ACLS_SLT: code = ALU_SLT;
            ACLS_FUNCT: begin
                if (opcode_i == OP_RTYPE) begin
                    case ({funct7_i, funct3_i})
                        {F7_BASE, 3'b000}: code = ALU_ADD;
                        {F7_ALT,  3'b000}: code = ALU_SUB;
                        {F7_BASE, 3'b001}: code = ALU_SLL;
                        {F7_BASE, 3'b010}: code = ALU_SLT;
                        {F7_BASE, 3'b011}: code = ALU_SLTU;
                        {F7_BASE, 3'b100}: code = ALU_XOR;
                        {F7_BASE, 3'b101}: code = ALU_SRL;
                        {F7_ALT,  3'b101}: code = ALU_SRA;
                        {F7_BASE, 3'b110}: code = ALU_OR;
                        {F7_BASE, 3'b111}: code = ALU_AND;
                        default:           code = ALU_ADD;
                    endcase
                end else if (opcode_i == OP_ITYPE) begin
                    // Shift-immediates only decode with the base funct7
                    case (funct3_i)
                        3'b001:  code = (funct7_i == F7_BASE) ? ALU_SLL : ALU_ADD;
                        3'b010:  code = ALU_SLT;
                        3'b101:  code = (funct7_i == F7_BASE) ? ALU_SRL : ALU_ADD;
                        3'b110:  code = ALU_OR;
                        3'b111:  code = ALU_AND;
                        default: code = ALU_ADD;
                    endcase
                end
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alu_control_o = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multi-cycle RV32I core; only pc_write and
// ir_write look at zero_i/mem_ready_i. MC_TRAP_EN adds a sticky TRAP state.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int ALU_CTRL_W = ALU_CTRL_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [6:0]            opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic                  zero_i,
    input  logic                  mem_ready_i,
    output logic                  pc_write_o,
    output logic                  ir_write_o,
    output logic                  adr_src_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [1:0]            mem_mode_o,
    output logic [1:0]            alu_src_a_o,
    output logic [1:0]            alu_src_b_o,
    output logic [1:0]            immsrc_o,
    output logic [1:0]            result_src_o,
    output logic                  reg_write_o,
    output logic [ALU_CTRL_W-1:0] alu_control_o
`ifdef MC_TRAP_EN
    ,
    output logic                  illegal_o
`endif
);

    state_e     state_q, state_d;
    alu_class_e alu_class;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
`ifdef MC_TRAP_EN
    logic       illegal_q, illegal_d;
    logic       ls_bad;

    assign ls_bad = (funct3_i != 3'b000) && (funct3_i != 3'b001) && (funct3_i != 3'b010);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
`ifdef MC_TRAP_EN
                    OP_LOAD, OP_STORE: state_d = ls_bad ? S_TRAP : S_MEMADR;
`else
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
`endif
                    OP_RTYPE:  state_d = S_EXECR;
                    OP_ITYPE:  state_d = S_EXECI;
                    OP_BRANCH: state_d = S_BRANCH;
`ifdef MC_TRAP_EN
                    default:   state_d = S_TRAP;
`else
                    default:   state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (opcode_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
`ifdef MC_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

`ifdef MC_TRAP_EN
    assign illegal_d = illegal_q | (state_d == S_TRAP);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
`ifdef MC_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
`ifdef MC_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    always_comb begin
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        adr_src_o    = 1'b0;
        mem_mode_o   = MODE_WORD;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_RS2;
        immsrc_o     = IMM_I;
        result_src_o = RES_ALUOUT;
        alu_class    = ACLS_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read     = 1'b1;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALU;
                pc_write     = mem_ready_i;
                ir_write     = mem_ready_i;
            end
            // Branch target is precomputed into ALUOut while decoding
            S_DECODE: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_IMM;
                immsrc_o    = IMM_B;
            end
            S_MEMADR: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                immsrc_o    = (opcode_i == OP_STORE) ? IMM_S : IMM_I;
                mem_mode_o  = mode_of(funct3_i);
            end
            S_MEMREAD: begin
                adr_src_o  = 1'b1;
                mem_read   = 1'b1;
                mem_mode_o = mode_of(funct3_i);
            end
            S_MEMWB: begin
                result_src_o = RES_DATA;
                reg_write    = 1'b1;
                mem_mode_o   = mode_of(funct3_i);
            end
            S_MEMWRITE: begin
                adr_src_o  = 1'b1;
                mem_write  = 1'b1;
                mem_mode_o = mode_of(funct3_i);
            end
            S_EXECR: begin
                alu_src_a_o = SRCA_RS1;
                alu_class   = ACLS_FUNCT;
            end
            S_EXECI: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                alu_class   = ACLS_FUNCT;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a_o = SRCA_RS1;
                case (funct3_i)
                    3'b000: begin alu_class = ACLS_SUB; pc_write = zero_i;  end
                    3'b001: begin alu_class = ACLS_SUB; pc_write = !zero_i; end
                    3'b100: begin alu_class = ACLS_SLT; pc_write = !zero_i; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    mc_alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decoder (
        .alu_class_i   (alu_class),
        .opcode_i      (opcode_i),
        .funct3_i      (funct3_i),
        .funct7_i      (funct7_i),
        .alu_control_o (alu_control_o)
    );

    // Reset kills every enable immediately, even mid-stall
    assign pc_write_o  = pc_write  & ~rst_i;
    assign ir_write_o  = ir_write  & ~rst_i;
    assign mem_read_o  = mem_read  & ~rst_i;
    assign mem_write_o = mem_write & ~rst_i;
    assign reg_write_o = reg_write & ~rst_i;
`ifdef MC_TRAP_EN
    assign illegal_o   = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-stream bench for multicycle_controller with a
// phase-sequence reference model and literal spot checks.
`timescale 1ns/1ps
module tb_multicycle_controller;

    typedef enum int {PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMREAD, PH_MEMWB, PH_MEMWRITE,
                      PH_EXECR, PH_EXECI, PH_ALUWB, PH_BRANCH, PH_TRAP} phase_t;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011;
    localparam logic [39:0] R_TAB = {5'd9, 5'd8, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd0};

    logic clk = 1'b0;
    logic rst_i, zero_i, mem_ready_i;
    logic [6:0] opcode_i, funct7_i;
    logic [2:0] funct3_i;
    logic pc_write_o, ir_write_o, adr_src_o, mem_read_o, mem_write_o, reg_write_o;
    logic [1:0] mem_mode_o, alu_src_a_o, alu_src_b_o, immsrc_o, result_src_o;
    logic [4:0] alu_control_o;
    logic illegal;

    int n_checks = 0, n_fails = 0;
    int force_zero = -1;
    int cyc;
    logic [21:0] exp_q[$];
    logic rec_rw[32], rec_adr[32], rec_pcw[32];
    logic [1:0] rec_mode[32];
    logic [4:0] rec_alu[32];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .adr_src_o(adr_src_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_mode_o(mem_mode_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .immsrc_o(immsrc_o),
        .result_src_o(result_src_o), .reg_write_o(reg_write_o),
        .alu_control_o(alu_control_o)
`ifdef MC_TRAP_EN
        , .illegal_o(illegal)
`endif
    );
`ifndef MC_TRAP_EN
    assign illegal = 1'b0;
`endif

    function automatic logic [1:0] ref_mode(input logic [2:0] f3);
        if (f3 == 3'd0) return 2'b00;
        if (f3 == 3'd1) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [4:0] ref_alu_r(input logic [6:0] f7, input logic [2:0] f3);
        logic [39:0] t;
        t = R_TAB;
        if (f7 == 7'h00) return t[int'(f3)*5 +: 5];
        if (f7 == 7'h20 && f3 == 3'd0) return 5'd1;
        if (f7 == 7'h20 && f3 == 3'd5) return 5'd7;
        return 5'd0;
    endfunction

    function automatic logic [4:0] ref_alu_i(input logic [6:0] f7, input logic [2:0] f3);
        case (f3)
            3'd1:    return (f7 == 7'h00) ? 5'd2 : 5'd0;
            3'd2:    return 5'd3;
            3'd5:    return (f7 == 7'h00) ? 5'd6 : 5'd0;
            3'd6:    return 5'd8;
            3'd7:    return 5'd9;
            default: return 5'd0;
        endcase
    endfunction

    // Expected outputs for one cycle of a given instruction phase
    function automatic logic [21:0] exp_vec(input phase_t ph, input logic rdy, input logic zr);
        logic pc, ir, adr, mr, mw, rw, ill;
        logic [1:0] mode, sa, sb, imm, res;
        logic [4:0] alu;
        pc = 0; ir = 0; adr = 0; mr = 0; mw = 0; rw = 0; ill = 0;
        mode = 2'b10; sa = 0; sb = 0; imm = 0; res = 0; alu = 0;
        case (ph)
            PH_FETCH:    begin mr = 1; sb = 2; res = 2; pc = rdy; ir = rdy; end
            PH_DECODE:   begin sa = 1; sb = 1; imm = 2; end
            PH_MEMADR:   begin sa = 2; sb = 1; imm = (opcode_i == STORE) ? 2'd1 : 2'd0;
                               mode = ref_mode(funct3_i); end
            PH_MEMREAD:  begin adr = 1; mr = 1; mode = ref_mode(funct3_i); end
            PH_MEMWB:    begin res = 1; rw = 1; mode = ref_mode(funct3_i); end
            PH_MEMWRITE: begin adr = 1; mw = 1; mode = ref_mode(funct3_i); end
            PH_EXECR:    begin sa = 2; alu = ref_alu_r(funct7_i, funct3_i); end
            PH_EXECI:    begin sa = 2; sb = 1; alu = ref_alu_i(funct7_i, funct3_i); end
            PH_ALUWB:    rw = 1;
            PH_BRANCH: begin
                sa = 2;
                if (funct3_i == 3'd0)      begin alu = 1; pc = zr;  end
                else if (funct3_i == 3'd1) begin alu = 1; pc = !zr; end
                else if (funct3_i == 3'd4) begin alu = 3; pc = !zr; end
            end
            PH_TRAP:     ill = 1;
            default: ;
        endcase
        return {ill, pc, ir, adr, mr, mw, mode, sa, sb, imm, res, rw, alu};
    endfunction

    function automatic logic [21:0] act_vec();
        return {illegal, pc_write_o, ir_write_o, adr_src_o, mem_read_o, mem_write_o,
                mem_mode_o, alu_src_a_o, alu_src_b_o, immsrc_o, result_src_o,
                reg_write_o, alu_control_o};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [21:0] e, a;
            e = exp_q.pop_front();
            a = act_vec();
            n_checks++;
            if (a !== e) begin
                n_fails++;
                $display("FAIL cycle_outputs t=%0t op=%b f3=%b f7=%b actual=%h required=%h",
                         $time, opcode_i, funct3_i, funct7_i, a, e);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic zsel();
        return (force_zero < 0) ? rb() : 1'(force_zero);
    endfunction

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode_i = op; funct3_i = f3; funct7_i = f7; cyc = 0;
    endtask

    task automatic drive(input phase_t ph, input logic rdy, input logic zr);
        mem_ready_i = rdy;
        zero_i      = zr;
        exp_q.push_back(exp_vec(ph, rdy, zr));
        #1;
        if (cyc < 32) begin
            rec_rw[cyc] = reg_write_o; rec_adr[cyc] = adr_src_o; rec_pcw[cyc] = pc_write_o;
            rec_mode[cyc] = mem_mode_o; rec_alu[cyc] = alu_control_o;
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input phase_t ph, input logic rdy, input logic zr);
        drive(ph, rdy, zr);
        tick();
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int wf, input int wm);
        set_instr(op, f3, f7);
        for (int w = 0; w <= wf; w++) step(PH_FETCH, w == wf, zsel());
        step(PH_DECODE, rb(), zsel());
        case (op)
            LOAD: begin
                step(PH_MEMADR, rb(), zsel());
                for (int w = 0; w <= wm; w++) step(PH_MEMREAD, w == wm, zsel());
                step(PH_MEMWB, rb(), zsel());
            end
            STORE: begin
                step(PH_MEMADR, rb(), zsel());
                for (int w = 0; w <= wm; w++) step(PH_MEMWRITE, w == wm, zsel());
            end
            RT:      begin step(PH_EXECR, rb(), zsel()); step(PH_ALUWB, rb(), zsel()); end
            IT:      begin step(PH_EXECI, rb(), zsel()); step(PH_ALUWB, rb(), zsel()); end
            BR:      step(PH_BRANCH, rb(), zsel());
            default: ;
        endcase
    endtask

    task automatic check_fetch(input string name);
        lit(name, {mem_read_o, adr_src_o, alu_src_b_o, result_src_o}, {1'b1, 1'b0, 2'b10, 2'b10});
    endtask

    initial begin
        logic [6:0] op, f7;
        logic [2:0] f3;
        int kind;
        rst_i = 1'b1; mem_ready_i = 1'b1; zero_i = 1'b1;
        set_instr(RT, 3'd0, 7'h00);
        #2;
        lit("reset_enables", {pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o}, 5'b0);
        lit("reset_selects", {adr_src_o, alu_src_a_o, alu_src_b_o, result_src_o, mem_mode_o},
            {1'b0, 2'b00, 2'b10, 2'b10, 2'b10});
        lit("reset_illegal", illegal, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // add x3,x1,x2
        set_instr(RT, 3'd0, 7'h00);
        drive(PH_FETCH, 1'b1, 1'b0);
        lit("first_fetch_strobe", mem_read_o, 1'b1);
        tick();
        step(PH_DECODE, 1'b0, 1'b0);
        step(PH_EXECR, 1'b0, 1'b0);
        step(PH_ALUWB, 1'b0, 1'b0);
        lit("add_alu", rec_alu[2], 5'd0);
        lit("add_regwrite", {rec_rw[3], rec_rw[2], rec_rw[1], rec_rw[0]}, 4'b1000);
        check_fetch("add_back_to_fetch");

        // lw with two MEMREAD wait cycles
        run_instr(LOAD, 3'b010, 7'h00, 0, 2);
        lit("lw_adr_stable", {rec_adr[5], rec_adr[4], rec_adr[3]}, 3'b111);
        lit("lw_mode_stable", {rec_mode[6], rec_mode[5], rec_mode[4], rec_mode[3], rec_mode[2]},
            10'b1010101010);
        lit("lw_regwrite", {rec_rw[6], rec_rw[5], rec_rw[4], rec_rw[3], rec_rw[2], rec_rw[1],
            rec_rw[0]}, 7'b1000000);
        check_fetch("lw_back_to_fetch");

        force_zero = 1;
        run_instr(BR, 3'b000, 7'h00, 0, 0);
        lit("beq_taken", rec_pcw[2], 1'b1);
        lit("beq_alu", rec_alu[2], 5'd1);
        check_fetch("beq_back_to_fetch");
        run_instr(BR, 3'b001, 7'h00, 0, 0);
        lit("bne_not_taken", rec_pcw[2], 1'b0);
        check_fetch("bne_back_to_fetch");
        force_zero = -1;

        run_instr(RT, 3'b101, 7'h20, 0, 0);
        lit("sra_alu", rec_alu[2], 5'd7);
        run_instr(IT, 3'b101, 7'h00, 0, 0);
        lit("srai_base_alu", rec_alu[2], 5'd6);

        // reset during a store stall
        set_instr(STORE, 3'b010, 7'h00);
        step(PH_FETCH, 1'b1, 1'b0);
        step(PH_DECODE, 1'b0, 1'b0);
        step(PH_MEMADR, 1'b0, 1'b0);
        step(PH_MEMWRITE, 1'b0, 1'b0);
        mem_ready_i = 1'b0;
        #1;
        lit("sw_stall_write", mem_write_o, 1'b1);
        rst_i = 1'b1;
        #1;
        lit("sw_reset_drops_write", mem_write_o, 1'b0);
        lit("sw_reset_enables", {pc_write_o, ir_write_o, reg_write_o, mem_read_o}, 4'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        lit("after_reset_fetch", {mem_read_o, adr_src_o}, 2'b10);
        tick();

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 6);
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            case (kind)
                0: op = LOAD;
                1: op = STORE;
                2: op = RT;
                3: op = IT;
                4: op = BR;
                5: op = 7'b0110111;
                default: op = 7'b1101111;
            endcase
`ifdef MC_TRAP_EN
            if ((op == LOAD || op == STORE) && f3 > 3'd2) f3 = 3'(f3 % 3);
            if (kind >= 5) op = RT;
`endif
            run_instr(op, f3, f7, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        set_instr(7'h7f, 3'd0, 7'h00);
        step(PH_FETCH, 1'b1, 1'b0);
        step(PH_DECODE, 1'b1, 1'b0);
`ifdef MC_TRAP_EN
        for (int k = 0; k < 4; k++) begin
            drive(PH_TRAP, rb(), rb());
            lit("trap_illegal", {illegal, pc_write_o, ir_write_o, mem_read_o, mem_write_o,
                reg_write_o}, 6'b100000);
            tick();
        end
        rst_i = 1'b1;
        #1;
        lit("trap_reset_clears", illegal, 1'b0);
        tick();
        rst_i = 1'b0;
        #1;
`endif
        check_fetch("unknown_or_reset_fetch");
        tick();

        lit("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multi-cycle RV32I core variant: a Moore FSM that walks each instruction through fetch, decode, execute, memory and writeback over several clocks, reusing one ALU and one unified instruction/data memory. Sits beside the datapath registers (PC, IR, OldPC, ALUOut, Data). Drives every mux select, write enable and memory strobe. Stalls on a single-signal memory ready handshake.

## Interface
- ALU_CTRL_W, 5, ALU control width; encoding is the core's existing one: add 0, sub 1, sll 2, slt 3, sltu 4, xor 5, srl 6, sra 7, or 8, and 9.
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, asynchronous, active-high.
- opcode_i  in  7  IR[6:0].
- funct3_i  in  3  IR[14:12].
- funct7_i  in  7  IR[31:25].
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- pc_write_o  out  1  PC load enable.
- ir_write_o  out  1  IR and OldPC load enable.
- adr_src_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- mem_mode_o  out  2  access size: 00 byte, 01 half, 10 word.
- alu_src_a_o  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b_o  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- immsrc_o  out  2  00 = I, 01 = S, 10 = B.
- result_src_o  out  2  00 = ALUOut, 01 = Data, 10 = ALU result.
- reg_write_o  out  1  register file write enable.
- alu_control_o  out  ALU_CTRL_W  ALU operation.
- illegal_o  out  1  sticky illegal-instruction flag; present only with MC_TRAP_EN.

## Operation
- States and per-state outputs. Unlisted enables are 0 and unlisted selects are 00.
  - FETCH: mem_read=1, adr_src=0, src_a=00, src_b=10, alu add, result_src=10. pc_write=ir_write=mem_ready_i. Stay until mem_ready_i, then go to DECODE.
  - DECODE: src_a=01, src_b=01, immsrc=10, add (precomputes branch target into ALUOut). Next state by opcode:
    - 0000011 or 0100011: MEMADR.
    - 0110011: EXECR.
    - 0010011: EXECI.
    - 1100011: BRANCH.
    - Other: FETCH (NOP).
  - MEMADR: src_a=10, src_b=01, add. immsrc=00 for loads, 01 for stores. Next: MEMREAD for loads, MEMWRITE for stores.
  - MEMREAD: adr_src=1, mem_read=1. Wait for mem_ready_i, then go to MEMWB.
  - MEMWB: result_src=01, reg_write=1. Next: FETCH.
  - MEMWRITE: adr_src=1, mem_write=1. Wait for mem_ready_i, then go to FETCH.
  - EXECR: src_a=10, src_b=00, alu from decoder. Next: ALUWB.
  - EXECI: src_a=10, src_b=01, immsrc=00, alu from decoder. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=1. Next: FETCH.
  - BRANCH: src_a=10, src_b=00, result_src=00. Next: FETCH.
    - funct3 000 (beq): alu sub, pc_write=zero_i.
    - funct3 001 (bne): alu sub, pc_write=!zero_i.
    - funct3 100 (blt): alu slt, pc_write=!zero_i.
- ALU decoder, R-type: {funct7,funct3} gives the ten codes above. funct7=0100000 selects sub (funct3 000) and sra (funct3 101).
- ALU decoder, I-type: addi 0, slli 2, slti 3, srli 6, ori 8, andi 9.
- mem_mode_o is decoded from funct3 in MEMADR, MEMREAD, MEMWRITE and MEMWB; 10 in all other states.
- Unsupported funct3/funct7 combinations decode to add (code 0).

## Timing
- Outputs are combinational from the state register. The only Mealy terms are pc_write_o and ir_write_o, which also use zero_i and mem_ready_i.
- Cycles per instruction with zero-wait memory: branch 3, R/I 4, store 4, load 5. Each wait cycle adds 1 in FETCH, MEMREAD or MEMWRITE.
- Reset:
  - State forces to FETCH asynchronously.
  - While rst_i=1, pc_write, ir_write, reg_write, mem_read and mem_write are forced to 0. Selects hold their FETCH values.
  - illegal_o clears to 0.
  - The first fetch strobe is in the first cycle after deassertion.
- Reset mid-operation, such as during a MEMWRITE stall, drops mem_write_o in the same cycle. No writeback occurs.
- mem_ready_i outside the FETCH, MEMREAD and MEMWRITE states is ignored.
- A strobe is held constant until ready; address and mode stay stable throughout the stall.

## Configuration
- MC_TRAP_EN defined:
  - An unknown opcode in DECODE, or a load/store with funct3 outside {000,001,010}, enters a TRAP state.
  - In TRAP all enables are 0 and illegal_o=1.
  - TRAP is left only by reset.
- MC_TRAP_EN undefined:
  - Unknown opcodes return to FETCH as a NOP.
  - A bad load/store funct3 uses word mode.
  - There is no illegal_o port and no TRAP state.

## Structure
- mc_pkg holds:
  - the state enum;
  - opcode localparams;
  - the Byte/HalfWord/Word mode constants;
  - ALU code localparams;
  - mux-select localparams for src_a, src_b, result_src and immsrc.
- One sub-module, mc_alu_decoder: combinational; inputs are state class (add, sub, slt or funct-decode), opcode, funct3 and funct7; output is alu_control.

## Test plan
- add x3,x1,x2 (0x002081B3), zero-wait memory:
  - states FETCH, DECODE, EXECR, ALUWB;
  - alu_control=0 in EXECR;
  - reg_write=1 only in cycle 4.
- lw (opcode 0000011, funct3 010) with mem_ready_i low for 2 cycles in MEMREAD:
  - 7 cycles total;
  - adr_src=1 and mem_mode=10 stable throughout;
  - reg_write only in MEMWB.
- beq with zero_i=1 → pc_write=1 in BRANCH. bne with zero_i=1 → pc_write=0. Both take 3 cycles.
- sra (funct7 0100000, funct3 101) → alu_control=7. srai (funct7 0000000, funct3 101) → alu_control=6.
- rst_i asserted during a MEMWRITE stall:
  - mem_write_o falls in the same cycle;
  - after release, FETCH is entered with mem_read=1.
- With MC_TRAP_EN, opcode 1111111:
  - TRAP is entered after DECODE;
  - illegal_o=1 and all enables stay 0 until reset;
  - without the macro the controller returns to FETCH.
